wb_commit_stage: RTL and testbench
==================================

WB_COMMIT_STAGE -- requirements
Module: wb_commit_stage

Interface
REQ-001 Parameter DW, default 64, register data width.
REQ-002 Parameter PCW, default 64, PC width.
REQ-003 Parameter NCH, default 2, write channels per bundle, range 1..4.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  discard all buffered and incoming bundles.
REQ-007 in_valid  input  1  memory stage presents a bundle.
REQ-008 in_ready  output  1  stage accepts a bundle this cycle.
REQ-009 in_pc  input  PCW  bundle PC; zero marks a bubble.
REQ-010 in_rd_ena  input  NCH  per-channel write enable.
REQ-011 in_rd_addr  input  NCH*5  per-channel destination, channel i at [5i+4:5i].
REQ-012 in_rd_data  input  NCH*DW  per-channel write data.
REQ-013 wb_valid  output  1  head bundle presented to regfile.
REQ-014 wb_ready  input  1  regfile consumes the head bundle.
REQ-015 wb_pc, wb_rd_ena, wb_rd_addr, wb_rd_data  output  PCW/NCH/NCH*5/NCH*DW  head bundle fields.

Function
REQ-016 The stage SHALL be a 2-entry FIFO, states EMPTY, ONE, FULL; in_ready = not FULL, registered.
REQ-017 Accept = in_valid and in_ready; pop = wb_valid and wb_ready; accept into EMPTY SHALL appear on wb_* the next cycle (1-cycle latency).
REQ-018 Transitions: EMPTY->ONE on accept; ONE->FULL on accept without pop; ONE->EMPTY on pop without accept; FULL->ONE on pop; simultaneous accept and pop in ONE SHALL stay ONE, preserving order.
REQ-019 In FULL, in_valid SHALL be ignored, in_ready SHALL be 0, and held data SHALL not change.
REQ-020 Bubbles (in_pc == 0) SHALL be accepted and popped as normal but with all wb_rd_ena bits forced 0.
REQ-021 A channel with rd_addr == 0 SHALL have its enable forced 0 at capture.
REQ-022 If two enabled channels of one bundle share a nonzero rd_addr, only the highest-index channel SHALL keep its enable.
REQ-023 flush SHALL empty the FIFO next cycle (state EMPTY, wb_valid 0) and drop any same-cycle input; flush has priority over accept and pop.
REQ-024 When wb_valid is 0, wb_rd_ena SHALL be all zero; other wb_* fields are don't-care but SHALL not be X after reset.
REQ-025 Read and write pointers SHALL be 1-bit and wrap 1->0.

Reset
REQ-026 While rst is 0: state EMPTY, in_ready 0, wb_valid 0, wb_pc 0, wb_rd_ena 0, wb_rd_addr 0, wb_rd_data 0, pointers 0, commit counter 0.
REQ-027 in_ready SHALL go to 1 on the first clk edge after rst deasserts; reset mid-operation SHALL discard all buffered bundles.

Configuration
REQ-028 Macro WB_COMMIT_TRACE_EN, when defined, SHALL add outputs commit_valid (1), commit_pc (PCW), commit_cnt (64).
REQ-029 With it: commit_valid pulses 1 cycle after each pop of a non-bubble bundle, commit_pc = popped PC, commit_cnt increments by 1 per such pop, wraps at 2^64.
REQ-030 Without it: these ports and the counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset, then in_valid=1 pc=0x80000000 ch0 rd=5 data=0x11, wb_ready=1 -> next cycle wb_valid=1, wb_rd_addr[4:0]=5, wb_rd_ena=01; commit_cnt=1 the cycle after.
REQ-032 wb_ready=0, three back-to-back bundles pc=0x100,0x104,0x108 -> in_ready=0 after two; release wb_ready -> pops 0x100 then 0x104, then accepts 0x108, order kept.
REQ-033 Bundle ch0 rd=7 data=0xA, ch1 rd=7 data=0xB, both enabled -> wb_rd_ena=10; bundle ch0 rd=0 ena=1 -> wb_rd_ena bit0=0.
REQ-034 FULL with flush=1 and in_valid=1 same cycle -> next cycle wb_valid=0, in_ready=1, dropped bundle never appears, commit_cnt unchanged.
REQ-035 Bubble pc=0 with ena=11 -> wb_valid=1, wb_rd_ena=00, commit_valid stays 0.
REQ-036 Assert rst=0 while FULL -> immediately wb_valid=0, in_ready=0; after release the FIFO is EMPTY.

Source files
------------

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: a 2-entry in-order FIFO between the memory stage and
// the register file. Write enables are sanitised at capture (bubbles, x0
// destinations, duplicate destinations within a bundle).
// Optional feature: define WB_COMMIT_TRACE_EN to add the commit_valid /
// commit_pc / commit_cnt trace outputs.
module wb_commit_stage #(
  parameter int unsigned DW  = 64,
  parameter int unsigned PCW = 64,
  parameter int unsigned NCH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PCW-1:0]      in_pc,
  input  logic [NCH-1:0]      in_rd_ena,
  input  logic [NCH*5-1:0]    in_rd_addr,
  input  logic [NCH*DW-1:0]   in_rd_data,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [PCW-1:0]      wb_pc,
  output logic [NCH-1:0]      wb_rd_ena,
  output logic [NCH*5-1:0]    wb_rd_addr,
  output logic [NCH*DW-1:0]   wb_rd_data
`ifdef WB_COMMIT_TRACE_EN
  ,
  output logic                commit_valid,
  output logic [PCW-1:0]      commit_pc,
  output logic [63:0]         commit_cnt
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e             state_q, state_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               in_ready_q, in_ready_d;

  logic [PCW-1:0]     pc_q   [2];
  logic [PCW-1:0]     pc_d   [2];
  logic [NCH-1:0]     ena_q  [2];
  logic [NCH-1:0]     ena_d  [2];
  logic [NCH*5-1:0]   addr_q [2];
  logic [NCH*5-1:0]   addr_d [2];
  logic [NCH*DW-1:0]  data_q [2];
  logic [NCH*DW-1:0]  data_d [2];

  logic               accept, pop, push, pop_eff;
  logic [NCH-1:0]     cap_ena;

  assign accept  = in_valid & in_ready_q;
  assign pop     = wb_valid & wb_ready;
  // Flush wins over both accept and pop.
  assign push    = accept & ~flush;
  assign pop_eff = pop & ~flush;

  // Sanitise enables: bubbles and x0 writes dropped, highest channel wins a duplicate.
  always_comb begin
    cap_ena = '0;
    for (int i = 0; i < NCH; i++) begin
      cap_ena[i] = in_rd_ena[i] && (in_rd_addr[5*i +: 5] != 5'd0) && (in_pc != '0);
      for (int j = i + 1; j < NCH; j++) begin
        if (in_rd_ena[j] && (in_rd_addr[5*j +: 5] == in_rd_addr[5*i +: 5])) begin
          cap_ena[i] = 1'b0;
        end
      end
    end
  end

  // Occupancy state, pointers and registered ready.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      state_d  = StEmpty;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push)    wr_ptr_d = ~wr_ptr_q;
      if (pop_eff) rd_ptr_d = ~rd_ptr_q;
      unique case (state_q)
        StEmpty: if (push) state_d = StOne;
        StOne: begin
          if (push && !pop_eff)      state_d = StFull;
          else if (pop_eff && !push) state_d = StEmpty;
        end
        StFull:  if (pop_eff) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
    in_ready_d = (state_d != StFull);
  end

  // Entry storage: written only on a non-flushed accept.
  always_comb begin
    pc_d   = pc_q;
    ena_d  = ena_q;
    addr_d = addr_q;
    data_d = data_q;
    if (push) begin
      pc_d[wr_ptr_q]   = in_pc;
      ena_d[wr_ptr_q]  = cap_ena;
      addr_d[wr_ptr_q] = in_rd_addr;
      data_d[wr_ptr_q] = in_rd_data;
    end
  end

  // State and storage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StEmpty;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        pc_q[k]   <= '0;
        ena_q[k]  <= '0;
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
      pc_q       <= pc_d;
      ena_q      <= ena_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // Head entry drives the regfile port; enables gated when nothing is held.
  always_comb begin
    in_ready   = in_ready_q;
    wb_valid   = (state_q != StEmpty);
    wb_pc      = pc_q[rd_ptr_q];
    wb_rd_ena  = wb_valid ? ena_q[rd_ptr_q] : '0;
    wb_rd_addr = addr_q[rd_ptr_q];
    wb_rd_data = data_q[rd_ptr_q];
  end

`ifdef WB_COMMIT_TRACE_EN
  logic           commit_valid_q, commit_valid_d;
  logic [PCW-1:0] commit_pc_q, commit_pc_d;
  logic [63:0]    commit_cnt_q, commit_cnt_d;

  // Trace: one pulse per popped non-bubble bundle.
  always_comb begin
    commit_valid_d = pop_eff && (wb_pc != '0);
    commit_pc_d    = commit_valid_d ? wb_pc : commit_pc_q;
    commit_cnt_d   = commit_cnt_q + {63'd0, commit_valid_d};
  end

  // Trace registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_cnt_q   <= '0;
    end else begin
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      commit_cnt_q   <= commit_cnt_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
  assign commit_cnt   = commit_cnt_q;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_wb_commit_stage;
  localparam int unsigned DW  = 64;
  localparam int unsigned PCW = 64;
  localparam int unsigned NCH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PCW-1:0]    in_pc;
  logic [NCH-1:0]    in_rd_ena;
  logic [NCH*5-1:0]  in_rd_addr;
  logic [NCH*DW-1:0] in_rd_data;
  logic              wb_valid;
  logic              wb_ready;
  logic [PCW-1:0]    wb_pc;
  logic [NCH-1:0]    wb_rd_ena;
  logic [NCH*5-1:0]  wb_rd_addr;
  logic [NCH*DW-1:0] wb_rd_data;
`ifdef WB_COMMIT_TRACE_EN
  logic              commit_valid;
  logic [PCW-1:0]    commit_pc;
  logic [63:0]       commit_cnt;
`endif

  wb_commit_stage #(.DW(DW), .PCW(PCW), .NCH(NCH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_rd_ena  (in_rd_ena),
    .in_rd_addr (in_rd_addr),
    .in_rd_data (in_rd_data),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_pc      (wb_pc),
    .wb_rd_ena  (wb_rd_ena),
    .wb_rd_addr (wb_rd_addr),
    .wb_rd_data (wb_rd_data)
`ifdef WB_COMMIT_TRACE_EN
    ,
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_cnt   (commit_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PCW-1:0]    pc;
    logic [NCH-1:0]    ena;
    logic [NCH*5-1:0]  addr;
    logic [NCH*DW-1:0] data;
  } bundle_t;

  bundle_t        model_q[$];
  bit             exp_ready;
  bit             exp_cv;
  logic [PCW-1:0] exp_cpc;
  logic [63:0]    exp_cnt;
  int             n_vec = 0;
  int             n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Effective enables from the rules: no bubbles, no x0, highest channel wins.
  function automatic logic [NCH-1:0] eff_ena(input logic [PCW-1:0] pc,
                                             input logic [NCH-1:0] ena,
                                             input logic [NCH*5-1:0] addr);
    logic [NCH-1:0] r;
    r = '0;
    if (pc != 0) begin
      for (int i = 0; i < NCH; i++) begin
        r[i] = ena[i] && (addr[5*i +: 5] != 0);
        for (int j = i + 1; j < NCH; j++)
          if (ena[j] && addr[5*j +: 5] == addr[5*i +: 5]) r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic check_all();
    check("wb_valid", wb_valid, model_q.size() != 0);
    check("in_ready", in_ready, exp_ready);
    if (model_q.size() != 0) begin
      check("wb_pc",      wb_pc,      model_q[0].pc);
      check("wb_rd_ena",  wb_rd_ena,  model_q[0].ena);
      check("wb_rd_addr", wb_rd_addr, model_q[0].addr);
      check("wb_rd_data", wb_rd_data, model_q[0].data);
    end else begin
      check("wb_rd_ena_idle", wb_rd_ena, '0);
    end
`ifdef WB_COMMIT_TRACE_EN
    check("commit_valid", commit_valid, exp_cv);
    if (exp_cv) check("commit_pc", commit_pc, exp_cpc);
    check("commit_cnt", commit_cnt, exp_cnt);
`endif
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model, check.
  task automatic step(input bit v, input logic [PCW-1:0] pc, input logic [NCH-1:0] ena,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input bit wr, input bit fl);
    bundle_t b;
    bit acc, pp;
    in_valid   = v;
    in_pc      = pc;
    in_rd_ena  = ena;
    in_rd_addr = {a1, a0};
    in_rd_data = {d1, d0};
    wb_ready   = wr;
    flush      = fl;
    acc    = v && exp_ready;
    pp     = (model_q.size() != 0) && wr;
    exp_cv = 1'b0;
    if (fl) begin
      model_q.delete();
    end else begin
      if (pp) begin
        b = model_q.pop_front();
        if (b.pc != 0) begin
          exp_cv  = 1'b1;
          exp_cpc = b.pc;
          exp_cnt = exp_cnt + 1;
        end
      end
      if (acc) begin
        b.pc   = pc;
        b.ena  = eff_ena(pc, ena, {a1, a0});
        b.addr = {a1, a0};
        b.data = {d1, d0};
        model_q.push_back(b);
      end
    end
    exp_ready = model_q.size() < 2;
    @(negedge clk);
    check_all();
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_ready = 1'b0;
    exp_cv    = 1'b0;
    exp_cnt   = '0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
    in_pc = '0; in_rd_ena = '0; in_rd_addr = '0; in_rd_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    check("rst_wb_pc",   wb_pc,      '0);
    check("rst_wb_addr", wb_rd_addr, '0);
    check("rst_wb_data", wb_rd_data, '0);
    rst = 1'b1;
    check("rdy_pre_edge", in_ready, 1'b0);

    // Single bundle, 1-cycle latency, then popped.
    step(0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
    step(1, 64'h8000_0000, 2'b01, 5, 0, 64'h11, 0, 1, 0);
    check("r31_addr", wb_rd_addr[4:0], 5'd5);
    check("r31_ena",  wb_rd_ena, 2'b01);
    step(0, 0, 2'b00, 0, 0, 0, 0, 1, 0);

    // Backpressure: fill to FULL, then drain in order.
    step(1, 64'h100, 2'b01, 1, 0, 64'hA0, 0, 0, 0);
    step(1, 64'h104, 2'b01, 2, 0, 64'hA4, 0, 0, 0);
    check("r32_full", in_ready, 1'b0);
    step(1, 64'h108, 2'b01, 3, 0, 64'hA8, 0, 0, 0);
    step(1, 64'h108, 2'b01, 3, 0, 64'hA8, 0, 1, 0);
    step(1, 64'h108, 2'b01, 3, 0, 64'hA8, 0, 1, 0);
    check("r32_order", wb_pc, 64'h108);
    step(0, 0, 2'b00, 0, 0, 0, 0, 1, 0);

    // Duplicate destination and x0 destination.
    step(1, 64'h200, 2'b11, 7, 7, 64'hA, 64'hB, 0, 0);
    check("r33_dup", wb_rd_ena, 2'b10);
    step(1, 64'h204, 2'b01, 0, 9, 64'hC, 64'hD, 1, 0);
    check("r33_x0", wb_rd_ena[0], 1'b0);
    step(0, 0, 2'b00, 0, 0, 0, 0, 1, 0);

    // Flush while FULL with a competing input.
    step(1, 64'h300, 2'b01, 4, 0, 1, 0, 0, 0);
    step(1, 64'h304, 2'b01, 4, 0, 2, 0, 0, 0);
    step(1, 64'h308, 2'b01, 4, 0, 3, 0, 1, 1);
    check("r34_valid", wb_valid, 1'b0);
    check("r34_ready", in_ready, 1'b1);
    step(0, 0, 2'b00, 0, 0, 0, 0, 1, 0);

    // Bubble with enables set.
    step(1, 64'h0, 2'b11, 3, 4, 5, 6, 0, 0);
    check("r35_ena", wb_rd_ena, 2'b00);
    step(0, 0, 2'b00, 0, 0, 0, 0, 1, 0);

    // Asynchronous reset while FULL.
    step(1, 64'h400, 2'b01, 8, 0, 1, 0, 0, 0);
    step(1, 64'h404, 2'b01, 9, 0, 2, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("r36_valid", wb_valid, 1'b0);
    check("r36_ready", in_ready, 1'b0);
    check("r36_pc",    wb_pc,    '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    check_all();
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [PCW-1:0] rpc;
      logic [4:0]     ra0, ra1;
      rpc = ($urandom_range(0, 4) == 0) ? '0 : {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) begin
        ra0 = 5'($urandom_range(0, 3));
        ra1 = 5'($urandom_range(0, 3));
      end else begin
        ra0 = 5'($urandom);
        ra1 = 5'($urandom);
      end
      step($urandom_range(0, 9) < 7, rpc, 2'($urandom), ra0, ra1,
           {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
